mem_port_arbiter: RTL and testbench

//  Shares one unified memory bus between fetch (imem) and data (dmem) requesters of riscv_core.

---
 rtl/riscv_arb_pkg.sv | 33 +++
 rtl/mem_port_arbiter_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared types for the imem/dmem memory port arbiter.
// FSM states, captured request bundle, grant encodings.
package riscv_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [1:0] GRANT_I = 2'b01;
    localparam logic [1:0] GRANT_D = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [3:0]            we;
    } mem_req_t;

    // dmem wins when alone, under fixed priority, or when imem had the last grant
    function automatic logic arb_pick_dmem(
        input logic i_v,
        input logic d_v,
        input logic fixed_prio,
        input logic last_d
    );
        return d_v && (!i_v || fixed_prio || !last_d);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter.
// Fires in the cycle the count reaches TIMEOUT_CYC-1 without completion.
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic busy_i,
    input  logic done_i,
    output logic expire_o
);

    localparam int CW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    logic [CW-1:0] r_cnt;

    // Count busy cycles that did not complete; restart on every new grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start_i) begin
            r_cnt <= '0;
        end else if (busy_i && !done_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry only when enabled and the bus has not answered this cycle
    always_comb begin
        expire_o = (TIMEOUT_CYC != 0) && busy_i && !done_i
                   && (r_cnt == CW'(LIM));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and data requesters.
// One transaction in flight; watchdog aborts stalled transfers.
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int                ADDR_W      = ARB_ADDR_W,
    parameter int                DATA_W      = ARB_DATA_W,
    parameter int                PRIO_MODE   = 0,
    parameter int                TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid_i,
    output logic              imem_ready_o,
    input  logic [ADDR_W-1:0] imem_addr_i,
    input  logic [DATA_W-1:0] imem_wdata_i,
    input  logic [3:0]        imem_we_i,
    output logic [DATA_W-1:0] imem_rdata_o,
    input  logic              dmem_valid_i,
    output logic              dmem_ready_o,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic [3:0]        dmem_we_i,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    arb_state_t r_state;
    arb_state_t w_next;
    mem_req_t   r_req;
    logic       r_last_d;
    logic       r_err;

    logic              w_pick_d;
    logic              w_pick_i;
    logic              w_start;
    logic              w_busy;
    logic              w_expire;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;

    // Requester selection and completion qualifiers
    always_comb begin
        w_pick_d = arb_pick_dmem(imem_valid_i, dmem_valid_i,
                                 PRIO_MODE != 0, r_last_d);
        w_pick_i = imem_valid_i && !w_pick_d;
        w_start  = (r_state == IDLE) && (w_pick_i || w_pick_d);
        w_busy   = (r_state != IDLE);
        w_done   = mem_ready_i || w_expire;
        w_rdata  = mem_ready_i ? mem_rdata_i : ERR_DATA;
    end

    arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .start_i (w_start),
        .busy_i  (w_busy),
        .done_i  (mem_ready_i),
        .expire_o(w_expire)
    );

    // Next-state logic: grant from IDLE, return on completion or abort
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_next = BUSY_D;
                end else if (w_pick_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Response muxes; the idle side always sees ready=0 and rdata=0
    always_comb begin
        mem_valid_o  = w_busy;
        grant_o      = '0;
        imem_ready_o = 1'b0;
        dmem_ready_o = 1'b0;
        imem_rdata_o = '0;
        dmem_rdata_o = '0;
        if (r_state == BUSY_I) begin
            grant_o      = GRANT_I;
            imem_ready_o = w_done;
            imem_rdata_o = w_done ? w_rdata : '0;
        end else if (r_state == BUSY_D) begin
            grant_o      = GRANT_D;
            dmem_ready_o = w_done;
            dmem_rdata_o = w_done ? w_rdata : '0;
        end
        mem_addr_o  = ADDR_W'(r_req.addr);
        mem_wdata_o = DATA_W'(r_req.wdata);
        mem_we_o    = r_req.we;
        err_o       = r_err;
    end

    // State, last-grant history and captured request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_req    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_last_d <= w_pick_d;
                if (w_pick_d) begin
                    r_req.addr  <= ARB_ADDR_W'(dmem_addr_i);
                    r_req.wdata <= ARB_DATA_W'(dmem_wdata_i);
                    r_req.we    <= dmem_we_i;
                end else begin
                    r_req.addr  <= ARB_ADDR_W'(imem_addr_i);
                    r_req.wdata <= ARB_DATA_W'(imem_wdata_i);
                    r_req.we    <= imem_we_i;
                end
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// u0: round-robin, 8-cycle watchdog; u1: fixed dmem priority.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, dv, mrdy, eclr;
    logic [31:0] ia, iw, da, dw, mrd;
    logic [3:0]  iwe, dwe;

    logic        i_rdy0, d_rdy0, mv0, err0;
    logic [31:0] i_rd0, d_rd0, ma0, mw0;
    logic [3:0]  mwe0;
    logic [1:0]  g0;

    logic        i_rdy1, d_rdy1, mv1, err1;
    logic [31:0] i_rd1, d_rd1, ma1, mw1;
    logic [3:0]  mwe1;
    logic [1:0]  g1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .PRIO_MODE(0), .TIMEOUT_CYC(8)
    ) u0 (
        .clk(clk), .rst(rst),
        .imem_valid_i(iv), .imem_ready_o(i_rdy0),
        .imem_addr_i(ia), .imem_wdata_i(iw),
        .imem_we_i(iwe), .imem_rdata_o(i_rd0),
        .dmem_valid_i(dv), .dmem_ready_o(d_rdy0),
        .dmem_addr_i(da), .dmem_wdata_i(dw),
        .dmem_we_i(dwe), .dmem_rdata_o(d_rd0),
        .mem_valid_o(mv0), .mem_ready_i(mrdy),
        .mem_addr_o(ma0), .mem_wdata_o(mw0),
        .mem_we_o(mwe0), .mem_rdata_i(mrd),
        .grant_o(g0), .err_o(err0), .err_clr_i(eclr)
    );

    mem_port_arbiter #(
        .PRIO_MODE(1), .TIMEOUT_CYC(0)
    ) u1 (
        .clk(clk), .rst(rst),
        .imem_valid_i(iv), .imem_ready_o(i_rdy1),
        .imem_addr_i(ia), .imem_wdata_i(iw),
        .imem_we_i(iwe), .imem_rdata_o(i_rd1),
        .dmem_valid_i(dv), .dmem_ready_o(d_rdy1),
        .dmem_addr_i(da), .dmem_wdata_i(dw),
        .dmem_we_i(dwe), .dmem_rdata_o(d_rd1),
        .mem_valid_o(mv1), .mem_ready_i(mrdy),
        .mem_addr_o(ma1), .mem_wdata_o(mw1),
        .mem_we_o(mwe1), .mem_rdata_i(mrd),
        .grant_o(g1), .err_o(err1), .err_clr_i(eclr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        iv = 0; dv = 0; mrdy = 0; eclr = 0;
        ia = 0; iw = 0; iwe = 0;
        da = 0; dw = 0; dwe = 0;
        mrd = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        zero_inputs();
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        zero_inputs();
        iv = 1; dv = 1; mrdy = 1; ia = 32'h77;
        step();
        step();
        #1;
        checks++;
        if ({mv0, g0, err0, i_rdy0, d_rdy0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {mv0, g0, err0, i_rdy0, d_rdy0});
        end
        checks++;
        if ({ma0, mw0, mwe0} !== 68'b0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h/%h want 0",
                     ma0, mw0, mwe0);
        end
        checks++;
        if ({mv1, g1, err1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_u1: got %b want 0000",
                     {mv1, g1, err1});
        end
        step();
        rst = 0;
        zero_inputs();
        step();
    endtask

    task automatic test_imem_only();
        reset_dut();
        iv = 1; ia = 32'h100; iw = 32'h0; iwe = 4'h0;
        mrd = 32'hCAFE_0001;
        #1;
        checks++;
        if (mv0 !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle_valid: got %b want 0", mv0);
        end
        step();
        iv = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mrdy = 1;
            #1;
            checks++;
            if ({mv0, g0, ma0} !== {1'b1, 2'b01, 32'h100}) begin
                errors++;
                $display("FAIL t1_busy%0d: got %b %b %h want 1 01 100",
                         k, mv0, g0, ma0);
            end
            checks++;
            if (i_rdy0 !== (k == 2) || d_rdy0 !== 1'b0) begin
                errors++;
                $display("FAIL t1_rdy%0d: got i=%b d=%b want i=%b d=0",
                         k, i_rdy0, d_rdy0, k == 2);
            end
            if (k == 2) begin
                checks++;
                if (i_rd0 !== 32'hCAFE_0001 || d_rd0 !== 32'h0) begin
                    errors++;
                    $display("FAIL t1_rdata: got %h/%h want cafe0001/0",
                             i_rd0, d_rd0);
                end
            end
            step();
        end
        mrdy = 0;
        #1;
        checks++;
        if ({mv0, g0, i_rdy0} !== 4'b0) begin
            errors++;
            $display("FAIL t1_after: got %b want 0000",
                     {mv0, g0, i_rdy0});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        reset_dut();
        iv = 1; dv = 1; ia = 32'h10; da = 32'h20;
        mrdy = 1; mrd = 32'h55;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            step();
            #1;
            checks++;
            if (g0 !== exp_g || mv0 !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b",
                         k, g0, exp_g);
            end
            checks++;
            if ({d_rdy0, i_rdy0} !== exp_g
                || ma0 !== (exp_g[1] ? 32'h20 : 32'h10)) begin
                errors++;
                $display("FAIL rr_rdy%0d: got %b a=%h want %b",
                         k, {d_rdy0, i_rdy0}, ma0, exp_g);
            end
            step();
            #1;
            checks++;
            if ({mv0, i_rdy0, d_rdy0} !== 3'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: got %b want 000",
                         k, {mv0, i_rdy0, d_rdy0});
            end
        end
    endtask

    task automatic test_fixed_prio();
        reset_dut();
        iv = 1; dv = 1; ia = 32'h10; da = 32'h20;
        mrdy = 1; mrd = 32'h66;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            checks++;
            if (g1 !== 2'b10 || d_rdy1 !== 1'b1 || i_rdy1 !== 1'b0) begin
                errors++;
                $display("FAIL prio%0d: got g=%b d=%b i=%b want 10 1 0",
                         k, g1, d_rdy1, i_rdy1);
            end
            step();
        end
        dv = 0;
        step();
        #1;
        checks++;
        if (g1 !== 2'b01 || i_rdy1 !== 1'b1 || ma1 !== 32'h10) begin
            errors++;
            $display("FAIL prio_imem: got g=%b i=%b a=%h want 01 1 10",
                     g1, i_rdy1, ma1);
        end
    endtask

    task automatic test_store_stable();
        reset_dut();
        dv = 1; da = 32'h2000; dw = 32'hA5A5; dwe = 4'b0011;
        step();
        dv = 0; da = 32'h3000; dw = 32'hFFFF; dwe = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({ma0, mw0, mwe0} !== {32'h2000, 32'hA5A5, 4'b0011}
                || d_rdy0 !== 1'b0) begin
                errors++;
                $display("FAIL st_hold%0d: got %h/%h/%b r=%b",
                         k, ma0, mw0, mwe0, d_rdy0);
            end
            step();
        end
        mrdy = 1; mrd = 32'h1357;
        #1;
        checks++;
        if (d_rdy0 !== 1'b1 || d_rd0 !== 32'h1357 || g0 !== 2'b10) begin
            errors++;
            $display("FAIL st_done: got r=%b d=%h g=%b want 1 1357 10",
                     d_rdy0, d_rd0, g0);
        end
        step();
        mrdy = 0;
        #1;
        checks++;
        if (mv0 !== 1'b0 || ma0 !== 32'h2000) begin
            errors++;
            $display("FAIL st_idle: got v=%b a=%h want 0 2000", mv0, ma0);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        iv = 1; ia = 32'h40;
        step();
        iv = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++;
            if (i_rdy0 !== (k == 8) || err0 !== 1'b0) begin
                errors++;
                $display("FAIL to_cyc%0d: got r=%b e=%b want r=%b e=0",
                         k, i_rdy0, err0, k == 8);
            end
            if (k == 8) begin
                checks++;
                if (i_rd0 !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL to_rdata: got %h want deadbeef", i_rd0);
                end
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (err0 !== 1'b1 || mv0 !== 1'b0 || i_rdy0 !== 1'b0) begin
                errors++;
                $display("FAIL to_sticky%0d: got e=%b v=%b r=%b want 1 0 0",
                         k, err0, mv0, i_rdy0);
            end
            step();
        end
        eclr = 1;
        step();
        eclr = 0;
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got %b want 0", err0);
        end
    endtask

    task automatic test_timeout_race();
        iv = 1; ia = 32'h44;
        step();
        iv = 0;
        for (int k = 0; k < 7; k++) step();
        mrdy = 1; mrd = 32'h1234;
        #1;
        checks++;
        if (i_rdy0 !== 1'b1 || i_rd0 !== 32'h1234) begin
            errors++;
            $display("FAIL race_rdy: got r=%b d=%h want 1 1234",
                     i_rdy0, i_rd0);
        end
        step();
        mrdy = 0;
        #1;
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL race_noerr: got %b want 0", err0);
        end
        iv = 1;
        step();
        iv = 0;
        for (int k = 0; k < 7; k++) step();
        eclr = 1;
        #1;
        checks++;
        if (i_rdy0 !== 1'b1 || i_rd0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL race_abort: got r=%b d=%h want 1 deadbeef",
                     i_rdy0, i_rd0);
        end
        step();
        eclr = 0;
        #1;
        checks++;
        if (err0 !== 1'b1) begin
            errors++;
            $display("FAIL race_clr: got %b want 1", err0);
        end
    endtask

    task automatic test_rst_mid();
        reset_dut();
        dv = 1; da = 32'h2000;
        step();
        dv = 0;
        #1;
        checks++;
        if (g0 !== 2'b10) begin
            errors++;
            $display("FAIL rm_busy: got %b want 10", g0);
        end
        #1;
        rst = 1; mrdy = 1;
        #1;
        checks++;
        if ({mv0, g0, d_rdy0, i_rdy0, err0} !== 6'b0 || ma0 !== 32'h0) begin
            errors++;
            $display("FAIL rm_async: got %b a=%h want 000000 0",
                     {mv0, g0, d_rdy0, i_rdy0, err0}, ma0);
        end
        #1;
        rst = 0; mrdy = 0;
        iv = 1; dv = 1; ia = 32'h10; da = 32'h20;
        step();
        #1;
        checks++;
        if (g0 !== 2'b10 || ma0 !== 32'h20) begin
            errors++;
            $display("FAIL rm_tie: got g=%b a=%h want 10 20", g0, ma0);
        end
    endtask

    initial begin
        test_reset();
        test_imem_only();
        test_round_robin();
        test_fixed_prio();
        test_store_stable();
        test_timeout();
        test_timeout_race();
        test_rst_mid();
        reset_dut();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
